// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the memory-game datapath: sequences rounds, owns the per-move timer.
// Optional move timeout is built only when EXP5_TIMEOUT_EN is defined.
module exp5_unidade_controle #(
   parameter int TIMEOUT_CICLOS = 3000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       enderecoIgualLimite,
   input  logic       fimL,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraL,
   output logic       contaL,
   output logic       zeraR,
   output logic       registraR,
   output logic       acertou,
   output logic       errou,
   output logic       pronto,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      INICIA_RODADA  = 4'h2,
      ESPERA_JOGADA  = 4'h3,
      REGISTRA       = 4'h4,
      COMPARACAO     = 4'h5,
      PROXIMA_JOGADA = 4'h6,
      PROXIMA_RODADA = 4'h7,
      FIM_ACERTOU    = 4'hA,
      FIM_TIMEOUT    = 4'hD,
      FIM_ERROU      = 4'hE
   } estado_t;

   if (TIMEOUT_CICLOS < 2 || TIMEOUT_CICLOS > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CICLOS out of range 2..65535");
   end

   estado_t    estado_q, estado_d;
   logic       timeout_w;
   logic [9:0] saidas_q;

`ifdef EXP5_TIMEOUT_EN
   localparam bit         TIMEOUT_EN = 1'b1;
   localparam logic [15:0] TIMER_ULTIMO = 16'(TIMEOUT_CICLOS - 1);

   logic [15:0] timer_q, timer_d;

   // Timer only runs in espera_jogada, so every entry there restarts from zero.
   always_comb begin
      timer_d = 16'd0;
      if (estado_q == ESPERA_JOGADA) timer_d = timer_q + 16'd1;
   end

   assign timeout_w = (estado_q == ESPERA_JOGADA) && (timer_q == TIMER_ULTIMO);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) timer_q <= 16'd0;
      else        timer_q <= timer_d;
   end
`else
   localparam bit TIMEOUT_EN = 1'b0;
   assign timeout_w = 1'b0;
`endif

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:        if (iniciar) estado_d = PREPARACAO;
         PREPARACAO:     estado_d = INICIA_RODADA;
         INICIA_RODADA:  estado_d = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            if (jogada)         estado_d = REGISTRA;
            else if (timeout_w) estado_d = FIM_TIMEOUT;
         end
         REGISTRA:       estado_d = COMPARACAO;
         COMPARACAO: begin
            if (!igual)                    estado_d = FIM_ERROU;
            else if (!enderecoIgualLimite) estado_d = PROXIMA_JOGADA;
            else if (!fimL)                estado_d = PROXIMA_RODADA;
            else                           estado_d = FIM_ACERTOU;
         end
         PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
         PROXIMA_RODADA: estado_d = INICIA_RODADA;
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                         if (iniciar) estado_d = PREPARACAO;
         default:        estado_d = INICIAL;
      endcase
   end

   // Bit order: zeraE contaE zeraL contaL zeraR registraR acertou errou pronto db_timeout
   function automatic logic [9:0] decodifica(estado_t e);
      logic [9:0] s;
      s = 10'd0;
      case (e)
         PREPARACAO:     begin s[9] = 1'b1; s[7] = 1'b1; s[5] = 1'b1; end
         INICIA_RODADA:  begin s[9] = 1'b1; s[5] = 1'b1; end
         REGISTRA:       s[4] = 1'b1;
         PROXIMA_JOGADA: s[8] = 1'b1;
         PROXIMA_RODADA: s[6] = 1'b1;
         FIM_ACERTOU:    begin s[3] = 1'b1; s[1] = 1'b1; end
         FIM_ERROU:      begin s[2] = 1'b1; s[1] = 1'b1; end
         FIM_TIMEOUT:    begin s[2] = 1'b1; s[1] = 1'b1; s[0] = TIMEOUT_EN; end
         default:        s = 10'd0;
      endcase
      return s;
   endfunction

   // Outputs are registered from the next state, so they always equal a decode of estado_q.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= INICIAL;
         saidas_q <= 10'd0;
      end else begin
         estado_q <= estado_d;
         saidas_q <= decodifica(estado_d);
      end
   end

   assign {zeraE, contaE, zeraL, contaL, zeraR, registraR,
           acertou, errou, pronto, db_timeout} = saidas_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Self-checking bench for exp5_unidade_controle: scripted game traces plus pinned literal checks.
module tb_exp5_unidade_controle;

  logic       clk;
  logic       reset;
  logic       iniciar, jogada, igual, enderecoIgualLimite, fimL;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       acertou, errou, pronto, db_timeout;
  logic [3:0] db_estado;

  exp5_unidade_controle #(.TIMEOUT_CICLOS(5)) dut (
    .clock(clk), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .enderecoIgualLimite(enderecoIgualLimite), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL), .zeraR(zeraR),
    .registraR(registraR), .acertou(acertou), .errou(errou), .pronto(pronto),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  typedef struct {
    string nome;
    int    act;
    int    exp;
  } pin_t;

  logic [3:0] exp_q[$];
  pin_t       pin_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         contal_cnt = 0;
  int         em3_cnt = 0;
  int         lat;

  // expected outputs for a state code, straight from the state/output table
  // order: zeraE contaE zeraL contaL zeraR registraR acertou errou pronto db_timeout
  function automatic logic [9:0] exp_outs(logic [3:0] s);
    case (s)
      4'h1:    return 10'b1010100000;
      4'h2:    return 10'b1000100000;
      4'h4:    return 10'b0000010000;
      4'h6:    return 10'b0100000000;
      4'h7:    return 10'b0001000000;
      4'hA:    return 10'b0000001010;
      4'hE:    return 10'b0000000110;
      4'hD:    return 10'b0000000111;
      default: return 10'b0000000000;
    endcase
  endfunction

  function automatic logic [9:0] dut_outs();
    return {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, pronto, db_timeout};
  endfunction

  // single compare process: per-cycle trace and queued literal pins
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (db_estado !== e || dut_outs() !== exp_outs(e)) begin
        n_bad++;
        $display("FAIL trace t=%0t: estado=%h outs=%b, required estado=%h outs=%b",
                 $time, db_estado, dut_outs(), e, exp_outs(e));
      end
    end
    while (pin_q.size() > 0) begin
      pin_t p;
      p = pin_q.pop_front();
      n_cmp++;
      if (p.act != p.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d, required %0d", p.nome, p.act, p.exp);
      end
    end
  end

  task automatic pin(input string nome, input int act, input int exp);
    pin_t p;
    p.nome = nome; p.act = act; p.exp = exp;
    pin_q.push_back(p);
  endtask

  // driver: one clock with current inputs, expect state e after the edge
  task automatic cyc(input logic [3:0] e);
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    if (contaL)            contal_cnt++;
    if (db_estado == 4'h3) em3_cnt++;
  endtask

  task automatic start_to_espera();
    iniciar = 1'b1; cyc(4'h1);
    iniciar = 1'b0; cyc(4'h2);
    cyc(4'h3);
  endtask

  // Four-position game; play (wr,wp) is wrong when wr >= 0.
  task automatic play_game(input int wr, input int wp, input bit idle);
    start_to_espera();
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p <= r; p++) begin
        int k;
        k = idle ? (r + p) % 4 : 0;
        for (int i = 0; i < k; i++) begin
          iniciar = 1'b1;
          cyc(4'h3);
          iniciar = 1'b0;
        end
        jogada = 1'b1;
        igual = !(r == wr && p == wp);
        enderecoIgualLimite = (p == r);
        fimL = (r == 3);
        cyc(4'h4);
        jogada = idle;
        cyc(4'h5);
        jogada = 1'b0;
        if (!igual) begin
          cyc(4'hE);
          return;
        end
        if (p < r) begin
          cyc(4'h6); cyc(4'h3);
        end else if (r < 3) begin
          cyc(4'h7); cyc(4'h2); cyc(4'h3);
        end else begin
          cyc(4'hA);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0;
    igual = 1'b0; enderecoIgualLimite = 1'b0; fimL = 1'b0;
    cyc(4'h0); cyc(4'h0);
    reset = 1'b1;
    cyc(4'h0);

    // iniciar ignored until asserted; start and measure move latency
    start_to_espera();
    jogada = 1'b1; igual = 1'b1; enderecoIgualLimite = 1'b0; fimL = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); @(negedge clk); #1;
      jogada = 1'b0;
      if (contaE) begin
        lat = i;
        break;
      end
    end
    pin("latencia_contaE", lat, 3);
    cyc(4'h3);

    // asynchronous reset in espera_jogada
    reset = 1'b0;
    #1;
    pin("reset_async_estado", int'(db_estado), 0);
    pin("reset_async_saidas", int'(dut_outs()), 0);
    cyc(4'h0);
    reset = 1'b1;
    cyc(4'h0);

    // full win with idle gaps, stray iniciar/jogada
    contal_cnt = 0;
    play_game(-1, -1, 1'b1);
    pin("contaL_pulsos", contal_cnt, 3);
    pin("ganhou_acertou", int'(acertou), 1);
    pin("ganhou_errou", int'(errou), 0);
    jogada = 1'b1; cyc(4'hA); cyc(4'hA);
    jogada = 1'b0;

    // wrong second play in round 2, then restart and win
    play_game(2, 1, 1'b0);
    pin("errou_flag", int'(errou), 1);
    pin("errou_acertou", int'(acertou), 0);
    cyc(4'hE);
    play_game(-1, -1, 1'b0);

`ifdef EXP5_TIMEOUT_EN
    // timeout: exactly 5 cycles in espera_jogada
    em3_cnt = 0;
    start_to_espera();
    cyc(4'h3); cyc(4'h3); cyc(4'h3); cyc(4'h3);
    cyc(4'hD);
    pin("ciclos_em_espera", em3_cnt, 5);
    pin("timeout_flag", int'(db_timeout), 1);

    // jogada on the last timer cycle wins; timer restarts afterwards
    start_to_espera();
    cyc(4'h3); cyc(4'h3); cyc(4'h3); cyc(4'h3);
    jogada = 1'b1; igual = 1'b1; enderecoIgualLimite = 1'b0; fimL = 1'b0;
    cyc(4'h4);
    pin("simultaneo_estado", int'(db_estado), 4);
    jogada = 1'b0;
    cyc(4'h5); cyc(4'h6); cyc(4'h3);
    em3_cnt = 0;
    cyc(4'h3); cyc(4'h3); cyc(4'h3); cyc(4'h3);
    cyc(4'hD);
    pin("ciclos_apos_reinicio", em3_cnt, 4);
`else
    // no timer: espera_jogada holds indefinitely
    em3_cnt = 0;
    start_to_espera();
    for (int i = 0; i < 10000; i++) cyc(4'h3);
    pin("sem_timeout_ciclos", em3_cnt, 10001);
    pin("sem_timeout_flag", int'(db_timeout), 0);
`endif

    @(negedge clk); #1;
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
